alu_arbiter: RTL and testbench

//   Shares one combinational ALU between two requesters (req0: pipeline EX, req1: address/aux unit).

---
 rtl/alu_arbiter.sv | 176 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 494 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters with round-robin grant.
// Latency: 2 cycles accept->rsp_valid for plain ops, MD_LAT+1 for MULT/DIV (one op in flight).
// Backpressure: no reqN_ready while executing or while a response waits on rsp_ready.
//
// Optional feature: define ALU_ARB_DIV0_TRAP_EN to trap DIV by zero without using the ALU.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   reqN_valid/ready/op/a/b      N=0,1 request handshake, op code and operands
//   alu_op, alu_in1, alu_in2     drive the shared ALU (zero outside EXEC)
//   alu_out, alu_zero, alu_neg   ALU results
//   rsp_valid/ready              response handshake
//   rsp_id, rsp_data, rsp_zero, rsp_neg, rsp_err   registered result and issuing requester
module alu_arbiter #(
    parameter int XLEN   = 32,
    parameter int MD_LAT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [4:0]      req0_op,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [4:0]      req1_op,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,
    output logic [4:0]      alu_op,
    output logic [XLEN-1:0] alu_in1,
    output logic [XLEN-1:0] alu_in2,
    input  logic [XLEN-1:0] alu_out,
    input  logic            alu_zero,
    input  logic            alu_neg,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [XLEN-1:0] rsp_data,
    output logic            rsp_zero,
    output logic            rsp_neg,
    output logic            rsp_err
);

    localparam logic [4:0]    OP_MULT = 5'd12;
    localparam logic [4:0]    OP_DIV  = 5'd13;
    localparam int            CW      = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;
    localparam logic [CW-1:0] MD_LOAD = CW'(MD_LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [4:0]      op_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic            id_q;
    logic            rr_ptr;
    logic [CW-1:0]   md_cnt;

    logic can_grant;
    logic grant0;
    logic grant1;
    logic accept;
    logic grant_id;
    logic div0_trap;
    logic is_md;
    logic capture;

    always_comb begin
        // A new request may be taken from IDLE, or from RESP in the same cycle
        // the consumer drains the result; rst masks ready so it reads 0 in reset.
        can_grant  = ~rst & ((state == IDLE) | ((state == RESP) & rsp_ready));
        grant0     = req0_valid & (~req1_valid | ~rr_ptr);
        grant1     = req1_valid & (~req0_valid | rr_ptr);
        req0_ready = can_grant & grant0;
        req1_ready = can_grant & grant1;
        accept     = req0_ready | req1_ready;
        grant_id   = req1_ready;

`ifdef ALU_ARB_DIV0_TRAP_EN
        div0_trap = (op_q == OP_DIV) && (b_q == '0);
`else
        div0_trap = 1'b0;
`endif
        // Trapped divides finish in one cycle, so they are not stretched.
        is_md   = ((op_q == OP_MULT) | (op_q == OP_DIV)) & ~div0_trap;
        capture = (state == EXEC) & (~is_md | (md_cnt == '0));

        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    if (capture) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = accept ? EXEC : IDLE;
            default: state_nxt = IDLE;
        endcase

        // Keep the ALU inputs quiet whenever no operation is executing.
        alu_op  = 5'd0;
        alu_in1 = '0;
        alu_in2 = '0;
        if ((state == EXEC) && !div0_trap) begin
            alu_op  = op_q;
            alu_in1 = a_q;
            alu_in2 = b_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= 5'd0;
            a_q       <= '0;
            b_q       <= '0;
            id_q      <= 1'b0;
            rr_ptr    <= 1'b0;
            md_cnt    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_zero  <= 1'b0;
            rsp_neg   <= 1'b0;
        end else begin
            if (accept) begin
                op_q   <= grant_id ? req1_op : req0_op;
                a_q    <= grant_id ? req1_a  : req0_a;
                b_q    <= grant_id ? req1_b  : req0_b;
                id_q   <= grant_id;
                rr_ptr <= ~grant_id;
                md_cnt <= MD_LOAD;
            end else if ((state == EXEC) && is_md && (md_cnt != '0)) begin
                md_cnt <= md_cnt - CW'(1);
            end

            if (capture) begin
                rsp_valid <= 1'b1;
                rsp_id    <= id_q;
                if (div0_trap) begin
                    rsp_data <= '1;
                    rsp_zero <= 1'b0;
                    rsp_neg  <= 1'b1;
                end else begin
                    rsp_data <= alu_out;
                    rsp_zero <= alu_zero;
                    rsp_neg  <= alu_neg;
                end
            end else if ((state == RESP) && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_ARB_DIV0_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_err <= 1'b0;
        end else if (capture) begin
            rsp_err <= div0_trap;
        end
    end
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: exercises alu_arbiter with directed scenarios and a randomized stream.
// A behavioural ALU stub sits on the ALU ports; expected results come from request operands.
// Each scenario task checks its own observations and the run ends with one summary line.
`timescale 1ns/1ps
module tb_alu_arbiter;
    localparam int XLEN   = 32;
    localparam int MD_LAT = 4;
`ifdef ALU_ARB_DIV0_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            req0_valid, req0_ready, req1_valid, req1_ready;
    logic [4:0]      req0_op, req1_op, alu_op;
    logic [XLEN-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [XLEN-1:0] alu_in1, alu_in2, alu_out, rsp_data;
    logic            alu_zero, alu_neg;
    logic            rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_neg, rsp_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    alu_arbiter #(.XLEN(XLEN), .MD_LAT(MD_LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_out(alu_out), .alu_zero(alu_zero), .alu_neg(alu_neg),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_neg(rsp_neg), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [XLEN-1:0] alu_f(input logic [4:0] op, input logic [XLEN-1:0] x,
                                              input logic [XLEN-1:0] y);
        case (op)
            5'd8:    return x + y;
            5'd10:   return x - y;
            5'd12:   return x * y;
            5'd13:   return (y == '0) ? {XLEN{1'b1}} : x / y;
            default: return x ^ y ^ {27'd0, op};
        endcase
    endfunction

    always_comb begin
        alu_out  = alu_f(alu_op, alu_in1, alu_in2);
        alu_zero = (alu_out == '0);
        alu_neg  = alu_out[XLEN-1];
    end

    typedef struct {
        logic            id;
        logic [XLEN-1:0] data;
        logic            zero;
        logic            neg;
        logic            err;
        int              lat;
        int              acc;
    } exp_t;

    // Expected response for a request, straight from the block's documented rules.
    function automatic exp_t model(input logic id, input logic [4:0] op, input logic [XLEN-1:0] a,
                                   input logic [XLEN-1:0] b);
        exp_t e;
        e.id  = id;
        e.acc = 0;
        if (TRAP && op == 5'd13 && b == '0) begin
            e.data = {XLEN{1'b1}};
            e.zero = 1'b0;
            e.neg  = 1'b1;
            e.err  = 1'b1;
            e.lat  = 2;
        end else begin
            e.data = alu_f(op, a, b);
            e.zero = (e.data == '0);
            e.neg  = e.data[XLEN-1];
            e.err  = 1'b0;
            e.lat  = (op == 5'd12 || op == 5'd13) ? MD_LAT + 1 : 2;
        end
        return e;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic v, input logic [4:0] op,
                           input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        if (r == 0) begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end
    endtask

    task automatic apply_reset;
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        tick;
    endtask

    // Raise one request and hold it until accepted; returns the accept cycle.
    task automatic issue(input int r, input logic [4:0] op, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, output int acc, output bit ok);
        ok  = 1'b0;
        acc = -1;
        set_req(r, 1'b1, op, a, b);
        for (int i = 0; i < 50; i++) begin
            #1;
            if ((r == 0 && req0_ready) || (r == 1 && req1_ready)) begin
                ok  = 1'b1;
                acc = cyc;
            end
            tick;
            if (ok) break;
        end
        if (r == 0) req0_valid = 1'b0;
        else        req1_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int at, output bit ok);
        ok = 1'b0;
        at = -1;
        for (int i = 0; i < 50; i++) begin
            if (rsp_valid) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
            tick;
        end
    endtask

    task automatic test_reset;
        int acc, at;
        bit ok;
        rst = 1'b1;
        rsp_ready = 1'b0;
        set_req(0, 1'b1, 5'd8, 32'd1, 32'd2);
        set_req(1, 1'b1, 5'd8, 32'd3, 32'd4);
        tick;
        tick;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            n_fail++; $display("FAIL reset_ready got=%b want=00", {req0_ready, req1_ready});
        end
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_zero, rsp_neg, rsp_err} !== 5'b0) begin
            n_fail++; $display("FAIL reset_rsp_flags got=%b want=0", {rsp_valid, rsp_id, rsp_zero, rsp_neg, rsp_err});
        end
        n_checks++;
        if (rsp_data !== '0) begin
            n_fail++; $display("FAIL reset_rsp_data got=%h want=0", rsp_data);
        end
        n_checks++;
        if ({alu_op, alu_in1, alu_in2} !== '0) begin
            n_fail++; $display("FAIL reset_alu got op=%0d in1=%h in2=%h want 0", alu_op, alu_in1, alu_in2);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b0;
        tick;

        // Reset in the middle of a stretched multiply.
        issue(1, 5'd12, 32'd3, 32'd4, acc, ok);
        tick;
        n_checks++;
        if (alu_op !== 5'd12) begin
            n_fail++; $display("FAIL reset_pre_exec alu_op got=%0d want=12", alu_op);
        end
        req0_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({alu_op, alu_in1, alu_in2, req0_ready} !== '0) begin
            n_fail++; $display("FAIL reset_mid_exec got op=%0d in1=%h in2=%h rdy0=%b want 0", alu_op, alu_in1, alu_in2, req0_ready);
        end
        req0_valid = 1'b0;
        tick;
        rst = 1'b0;
        tick;

        // Reset while a response is stalled.
        issue(0, 5'd8, 32'd1, 32'd2, acc, ok);
        wait_rsp(at, ok);
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++; $display("FAIL reset_pre_resp rsp_valid got=0 want=1");
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({rsp_valid, rsp_data} !== '0) begin
            n_fail++; $display("FAIL reset_mid_resp got valid=%b data=%h want 0", rsp_valid, rsp_data);
        end
        tick;
        rst = 1'b0;
        tick;

        rsp_ready = 1'b1;
        issue(0, 5'd8, 32'd20, 32'd22, acc, ok);
        wait_rsp(at, ok);
        n_checks++;
        if (!ok || at != acc + 2 || rsp_data !== 32'd42) begin
            n_fail++; $display("FAIL reset_recover got ok=%b lat=%0d data=%0d want lat=2 data=42", ok, at - acc, rsp_data);
        end
        tick;
    endtask

    task automatic test_add;
        int acc, at;
        bit ok;
        rsp_ready = 1'b1;
        issue(0, 5'd8, 32'd5, 32'd7, acc, ok);
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++; $display("FAIL add_accept got=timeout want=accept");
        end
        wait_rsp(at, ok);
        n_checks++;
        if (!ok || at != acc + 2) begin
            n_fail++; $display("FAIL add_latency got=%0d want=2", at - acc);
        end
        n_checks++;
        if ({rsp_id, rsp_data, rsp_zero, rsp_neg, rsp_err} !== {1'b0, 32'd12, 3'b000}) begin
            n_fail++; $display("FAIL add_result got id=%b data=%0d z=%b n=%b e=%b want id=0 data=12 flags 0", rsp_id, rsp_data, rsp_zero, rsp_neg, rsp_err);
        end
        tick;
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL add_drain rsp_valid got=1 want=0");
        end
    endtask

    task automatic test_alternate;
        exp_t q0[$], q1[$];
        exp_t e;
        int grants, rsps;
        bit g0, g1;
        apply_reset;
        rsp_ready = 1'b1;
        grants = 0;
        rsps = 0;
        set_req(0, 1'b1, 5'd10, $urandom, $urandom);
        set_req(1, 1'b1, 5'd10, $urandom, $urandom);
        for (int i = 0; i < 60 && rsps < 8; i++) begin
            #1;
            g0 = 1'b0;
            g1 = 1'b0;
            if (rsp_valid && rsp_ready) begin
                if (rsp_id === 1'b0 && q0.size() > 0) e = q0.pop_front();
                else if (rsp_id === 1'b1 && q1.size() > 0) e = q1.pop_front();
                else e.data = ~rsp_data;
                n_checks++;
                if (rsp_data !== e.data) begin
                    n_fail++; $display("FAIL alt_data id=%b got=%h want=%h", rsp_id, rsp_data, e.data);
                end
                rsps++;
            end
            n_checks++;
            if (req0_ready && req1_ready) begin
                n_fail++; $display("FAIL alt_double_grant got=11 want one-hot");
            end
            if (req0_ready || req1_ready) begin
                n_checks++;
                if (req1_ready !== grants[0]) begin
                    n_fail++; $display("FAIL alt_order grant#%0d got=%b want=%b", grants, req1_ready, grants[0]);
                end
                if (req0_ready) begin
                    q0.push_back(model(1'b0, req0_op, req0_a, req0_b)); g0 = 1'b1;
                end else begin
                    q1.push_back(model(1'b1, req1_op, req1_a, req1_b)); g1 = 1'b1;
                end
                grants++;
            end
            tick;
            if (g0) set_req(0, grants < 8, 5'd10, $urandom, $urandom);
            if (g1) set_req(1, grants < 8, 5'd10, $urandom, $urandom);
            if (grants >= 8) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
        end
        n_checks++;
        if (rsps != 8 || grants != 8) begin
            n_fail++; $display("FAIL alt_count got grants=%0d rsps=%0d want 8/8", grants, rsps);
        end
    endtask

    task automatic test_mult;
        int acc;
        bit ok;
        rsp_ready = 1'b1;
        issue(1, 5'd12, 32'd3, 32'd4, acc, ok);
        for (int i = 0; i < MD_LAT; i++) begin
            n_checks++;
            if ({alu_op, alu_in1, alu_in2, rsp_valid} !== {5'd12, 32'd3, 32'd4, 1'b0}) begin
                n_fail++; $display("FAIL mult_hold cyc%0d got op=%0d in1=%0d in2=%0d v=%b want 12/3/4/0", i, alu_op, alu_in1, alu_in2, rsp_valid);
            end
            tick;
        end
        n_checks++;
        if (!ok || cyc != acc + MD_LAT + 1 || {rsp_valid, rsp_id, rsp_data} !== {2'b11, 32'd12}) begin
            n_fail++; $display("FAIL mult_result got lat=%0d v=%b id=%b data=%0d want lat=%0d v=1 id=1 data=12", cyc - acc, rsp_valid, rsp_id, rsp_data, MD_LAT + 1);
        end
        n_checks++;
        if (alu_op !== 5'd0) begin
            n_fail++; $display("FAIL mult_idle_alu got op=%0d want=0", alu_op);
        end
        tick;
    endtask

    task automatic test_stall;
        int acc, at;
        bit ok;
        rsp_ready = 1'b0;
        issue(1, 5'd8, 32'd100, 32'd11, acc, ok);
        wait_rsp(at, ok);
        set_req(0, 1'b1, 5'd10, 32'd50, 32'd8);
        for (int i = 0; i < 6; i++) begin
            #1;
            n_checks++;
            if ({rsp_valid, rsp_id, rsp_data, req0_ready} !== {2'b11, 32'd111, 1'b0}) begin
                n_fail++; $display("FAIL stall_hold cyc%0d got v=%b id=%b data=%0d rdy0=%b want 1/1/111/0", i, rsp_valid, rsp_id, rsp_data, req0_ready);
            end
            tick;
        end
        rsp_ready = 1'b1;
        #1;
        n_checks++;
        if (req0_ready !== 1'b1) begin
            n_fail++; $display("FAIL stall_release_accept rdy0 got=%b want=1", req0_ready);
        end
        tick;
        req0_valid = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL stall_drain rsp_valid got=1 want=0");
        end
        tick;
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_data} !== {2'b10, 32'd42}) begin
            n_fail++; $display("FAIL stall_next got v=%b id=%b data=%0d want 1/0/42", rsp_valid, rsp_id, rsp_data);
        end
        tick;
    endtask

    task automatic test_div0;
        int acc, at;
        bit ok;
        exp_t e;
        logic [4:0] want_op;
        rsp_ready = 1'b1;
        e = model(1'b0, 5'd13, 32'd9, 32'd0);
        want_op = TRAP ? 5'd0 : 5'd13;
        issue(0, 5'd13, 32'd9, 32'd0, acc, ok);
        n_checks++;
        if (alu_op !== want_op) begin
            n_fail++; $display("FAIL div0_alu_op got=%0d want=%0d", alu_op, want_op);
        end
        wait_rsp(at, ok);
        n_checks++;
        if (!ok || at != acc + e.lat) begin
            n_fail++; $display("FAIL div0_latency got=%0d want=%0d", at - acc, e.lat);
        end
        n_checks++;
        if ({rsp_data, rsp_zero, rsp_neg, rsp_err} !== {e.data, e.zero, e.neg, e.err}) begin
            n_fail++; $display("FAIL div0_result got data=%h z=%b n=%b e=%b want data=%h z=%b n=%b e=%b", rsp_data, rsp_zero, rsp_neg, rsp_err, e.data, e.zero, e.neg, e.err);
        end
        tick;
    endtask

    task automatic test_random;
        logic [4:0]      rop[2];
        logic [XLEN-1:0] ra[2], rb[2];
        bit              v[2], took[2];
        exp_t            e, held;
        bit              have_exp, prev_stall, both;
        int              last, nrsp;
        apply_reset;
        v[0] = 1'b0; v[1] = 1'b0;
        have_exp = 1'b0;
        prev_stall = 1'b0;
        last = 1;
        nrsp = 0;
        for (int c = 0; c < 800 && nrsp < 80; c++) begin
            for (int r = 0; r < 2; r++) begin
                if (!v[r] && $urandom_range(0, 1) == 1) begin
                    case ($urandom_range(0, 4))
                        0:       rop[r] = 5'd8;
                        1:       rop[r] = 5'd10;
                        2:       rop[r] = 5'd12;
                        3:       rop[r] = 5'd13;
                        default: rop[r] = 5'($urandom_range(0, 31));
                    endcase
                    ra[r] = $urandom;
                    rb[r] = ($urandom_range(0, 3) == 0) ? '0 : $urandom;
                    set_req(r, 1'b1, rop[r], ra[r], rb[r]);
                    v[r] = 1'b1;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (rsp_valid) begin
                n_checks++;
                if (!prev_stall) begin
                    if (!have_exp || {rsp_id, rsp_data, rsp_zero, rsp_neg, rsp_err} !== {e.id, e.data, e.zero, e.neg, e.err} || cyc != e.acc + e.lat) begin
                        n_fail++; $display("FAIL rnd_rsp got id=%b data=%h znE=%b%b%b lat=%0d want id=%b data=%h znE=%b%b%b lat=%0d", rsp_id, rsp_data, rsp_zero, rsp_neg, rsp_err, cyc - e.acc, e.id, e.data, e.zero, e.neg, e.err, e.lat);
                    end
                    held = e;
                end else if ({rsp_id, rsp_data, rsp_err} !== {held.id, held.data, held.err}) begin
                    n_fail++; $display("FAIL rnd_stable got id=%b data=%h want id=%b data=%h", rsp_id, rsp_data, held.id, held.data);
                end
                n_checks++;
                if (!rsp_ready && (req0_ready || req1_ready)) begin
                    n_fail++; $display("FAIL rnd_stall_grant got rdy=%b%b want 00", req1_ready, req0_ready);
                end
                if (rsp_ready) begin
                    nrsp++;
                    have_exp = 1'b0;
                end
                prev_stall = !rsp_ready;
            end else begin
                prev_stall = 1'b0;
            end
            n_checks++;
            if (rsp_valid && alu_op !== 5'd0) begin
                n_fail++; $display("FAIL rnd_alu_quiet got op=%0d want=0", alu_op);
            end
            both = v[0] && v[1];
            took[0] = req0_ready;
            took[1] = req1_ready;
            if (took[0] || took[1]) begin
                n_checks++;
                if ((took[0] && took[1]) || (both && ((took[1] ? 1 : 0) == last))) begin
                    n_fail++; $display("FAIL rnd_arb got rdy=%b%b last=%0d both=%b want one-hot alternating", took[1], took[0], last, both);
                end
                last = took[1] ? 1 : 0;
                e = model(1'(last), rop[last], ra[last], rb[last]);
                e.acc = cyc;
                have_exp = 1'b1;
            end
            tick;
            for (int r = 0; r < 2; r++) begin
                if (took[r]) begin
                    v[r] = 1'b0;
                    set_req(r, 1'b0, rop[r], ra[r], rb[r]);
                end
            end
        end
        n_checks++;
        if (nrsp < 40) begin
            n_fail++; $display("FAIL rnd_progress got=%0d responses want>=40", nrsp);
        end
    endtask

    initial begin
        rst = 1'b1;
        rsp_ready = 1'b0;
        set_req(0, 1'b0, 5'd0, '0, '0);
        set_req(1, 1'b0, 5'd0, '0, '0);
        #1;
        test_reset;
        test_add;
        test_alternate;
        test_mult;
        test_stall;
        test_div0;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
